lsw_drain: RTL

In-order drain stage for the store data buffer (`lsw_data`). It tracks retired stores and reads their entries from the buffer in program order, two per cycle. It presents them to the L1 data-cache write port on two valid/ready lanes. Once an entry is accepted, it returns the entry's index to the store allocator for reuse.

---
 rtl/lsq_pkg.sv | 18 +
 rtl/lsw_idx_add.sv | 22 ++
 rtl/lsw_drain.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared store-queue definitions: store data buffer sizes, payload layout
// and entry index type.
package lsq_pkg;

    localparam int LSW_DATA_WIDTH = 139;
    localparam int LSW_ENTRIES = 240;

    typedef logic [7:0] lsw_idx_t;

    // Payload layout, msb first: size, byte enables, high-half valid, data.
    typedef struct packed {
        logic [1:0]   size;
        logic [7:0]   byte_en;
        logic         hi_valid;
        logic [127:0] data;
    } lsw_entry_t;

endpackage

// File: rtl/lsw_idx_add.sv
// Modular index adder: idx + inc (0..2), wrapping at N back to 0.
module lsw_idx_add #(
    parameter int W = 8,
    parameter int N = 240
) (
    input  logic [W-1:0] idx,
    input  logic [1:0]   inc,
    output logic [W-1:0] sum
);

    localparam logic [W:0] LIMIT = (W+1)'(N);

    logic [W:0] raw;
    logic [W:0] wrapped;

    always_comb begin
        raw = {1'b0, idx} + (W+1)'(inc);
        wrapped = raw - LIMIT;
        sum = (raw >= LIMIT) ? wrapped[W-1:0] : raw[W-1:0];
    end

endmodule

// File: rtl/lsw_drain.sv
// In-order drain of retired stores from the store data buffer onto two
// ordered cache write lanes, returning accepted indices to the allocator.
module lsw_drain
    import lsq_pkg::*;
#(
    parameter int DATA_WIDTH = LSW_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int ENTRY_COUNT = LSW_ENTRIES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_init,
    input  logic [1:0]            retire_cnt,
    output logic [ADDR_WIDTH-1:0] read_addr0,
    output logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [DATA_WIDTH-1:0] read_data0,
    input  logic [DATA_WIDTH-1:0] read_data1,
    output logic                  wr_valid0,
    output logic                  wr_valid1,
    output logic [DATA_WIDTH-1:0] wr_data0,
    output logic [DATA_WIDTH-1:0] wr_data1,
    output logic [ADDR_WIDTH-1:0] wr_idx0,
    output logic [ADDR_WIDTH-1:0] wr_idx1,
    input  logic                  wr_ready0,
    input  logic                  wr_ready1,
    output logic                  free_en,
    output logic [1:0]            free_cnt,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic [ADDR_WIDTH-1:0] pending,
    output logic                  overflow
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] ENTRIES = (AW+1)'(ENTRY_COUNT);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] free_ptr;
    logic [AW-1:0] free_next;

    logic          fire0;
    logic          fire1;
    logic [1:0]    fire_cnt;
    logic [1:0]    lanes_cnt;
    logic [1:0]    kept;
    logic [1:0]    room;
    logic [1:0]    fill;

    logic [AW:0]   sum_chk;
    logic [AW:0]   pend_raw;
    logic [AW:0]   pend_cap;
    logic [AW-1:0] pend_next;

    logic                  n_valid0;
    logic                  n_valid1;
    logic [DATA_WIDTH-1:0] n_data0;
    logic [DATA_WIDTH-1:0] n_data1;
    logic [AW-1:0]         n_idx0;
    logic [AW-1:0]         n_idx1;

    assign read_addr0 = rd_ptr;

    lsw_idx_add #(.W(AW), .N(ENTRY_COUNT)) u_rd_plus1 (
        .idx (rd_ptr),
        .inc (2'd1),
        .sum (read_addr1)
    );

    lsw_idx_add #(.W(AW), .N(ENTRY_COUNT)) u_rd_adv (
        .idx (rd_ptr),
        .inc (fill),
        .sum (rd_next)
    );

    lsw_idx_add #(.W(AW), .N(ENTRY_COUNT)) u_free_adv (
        .idx (free_ptr),
        .inc (fire_cnt),
        .sum (free_next)
    );

    // Lane 1 only fires alongside lane 0, so lane 1 valid implies lane 0 valid.
    always_comb begin
        fire0 = wr_valid0 & wr_ready0;
        fire1 = fire0 & wr_valid1 & wr_ready1;
        fire_cnt = {1'b0, fire0} + {1'b0, fire1};
        lanes_cnt = {1'b0, wr_valid0} + {1'b0, wr_valid1};
        kept = lanes_cnt - fire_cnt;
        room = 2'd2 - kept;
        if (buf_init)
            fill = 2'd0;
        else if (pending >= AW'(room))
            fill = room;
        else
            fill = pending[1:0];
    end

    always_comb begin
        n_valid0 = 1'b0;
        n_data0 = wr_data0;
        n_idx0 = wr_idx0;
        if (!fire0 && wr_valid0) begin
            n_valid0 = 1'b1;
        end else if (fire0 && !fire1 && wr_valid1) begin
            n_valid0 = 1'b1;
            n_data0 = wr_data1;
            n_idx0 = wr_idx1;
        end else if (fill != 2'd0) begin
            n_valid0 = 1'b1;
            n_data0 = read_data0;
            n_idx0 = read_addr0;
        end
    end

    always_comb begin
        n_valid1 = 1'b0;
        n_data1 = wr_data1;
        n_idx1 = wr_idx1;
        if (!fire0 && wr_valid1) begin
            n_valid1 = 1'b1;
        end else if (kept == 2'd1 && fill != 2'd0) begin
            n_valid1 = 1'b1;
            n_data1 = read_data0;
            n_idx1 = read_addr0;
        end else if (kept == 2'd0 && fill == 2'd2) begin
            n_valid1 = 1'b1;
            n_data1 = read_data1;
            n_idx1 = read_addr1;
        end
    end

    // Cap pending so pending plus occupied lanes never exceeds the buffer.
    always_comb begin
        sum_chk = (AW+1)'(pending) + (AW+1)'(lanes_cnt) + (AW+1)'(retire_cnt);
        pend_raw = (AW+1)'(pending) + (AW+1)'(retire_cnt) - (AW+1)'(fill);
        pend_cap = ENTRIES - (AW+1)'(kept + fill);
        pend_next = (pend_raw > pend_cap) ? pend_cap[AW-1:0] : pend_raw[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            free_ptr <= '0;
            pending <= '0;
            overflow <= 1'b0;
            wr_valid0 <= 1'b0;
            wr_valid1 <= 1'b0;
            wr_data0 <= '0;
            wr_data1 <= '0;
            wr_idx0 <= '0;
            wr_idx1 <= '0;
            free_en <= 1'b0;
            free_cnt <= 2'd0;
            free_addr <= '0;
        end else begin
            rd_ptr <= rd_next;
            free_ptr <= free_next;
            pending <= pend_next;
            if (sum_chk > ENTRIES)
                overflow <= 1'b1;
            wr_valid0 <= n_valid0;
            wr_valid1 <= n_valid1;
            wr_data0 <= n_data0;
            wr_data1 <= n_data1;
            wr_idx0 <= n_idx0;
            wr_idx1 <= n_idx1;
            free_en <= (fire_cnt != 2'd0);
            free_cnt <= fire_cnt;
            free_addr <= free_ptr;
        end
    end

endmodule
